// File: rtl/sprite_anim_renderer.sv
// Sprite renderer for the VGA pixel path. It maps DrawX/DrawY into a multi-frame
// sprite sheet in an external ROM, then scales, flips, colour-keys and animates the sprite.
module sprite_anim_renderer #(
  parameter int SPRITE_W        = 32,
  parameter int SPRITE_H        = 32,
  parameter int FRAMES          = 4,
  parameter int IDX_W           = 3,
  parameter int SCALE_SHIFT     = 1,
  parameter int FRAME_PERIOD    = 8,
  parameter int TRANSPARENT_IDX = 0,
  parameter int ROM_LATENCY     = 1,
  localparam int ADDR_W  = $clog2(FRAMES * SPRITE_W * SPRITE_H),
  localparam int FRAME_W = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset,
  input  logic [9:0]         DrawX,
  input  logic [9:0]         DrawY,
  input  logic               blank,
  input  logic               enable,
  input  logic               anim_en,
  input  logic               flip_h,
  input  logic [9:0]         sprite_x,
  input  logic [9:0]         sprite_y,
  input  logic [3:0]         bg_red,
  input  logic [3:0]         bg_green,
  input  logic [3:0]         bg_blue,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [IDX_W-1:0]   rom_q,
  output logic [IDX_W-1:0]   pal_index,
  input  logic [3:0]         pal_red,
  input  logic [3:0]         pal_green,
  input  logic [3:0]         pal_blue,
  output logic [FRAME_W-1:0] cur_frame,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  localparam int TX_W   = $clog2(SPRITE_W);
  localparam int TY_W   = $clog2(SPRITE_H);
  localparam int TICK_W = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
  localparam int DEPTH  = 1 + ROM_LATENCY;
  localparam logic [10:0] SPAN_X = 11'(SPRITE_W << SCALE_SHIFT);
  localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_SHIFT);

  logic [10:0]        dx, dy;
  logic               hit_d;
  logic [TX_W-1:0]    tx;
  logic [TY_W-1:0]    ty;
  logic [ADDR_W-1:0]  addr_d, rom_addr_q;
  logic [DEPTH-1:0]   hit_q, blank_q;
  logic [11:0]        bg_q [DEPTH];
  logic [11:0]        rgb_d, rgb_q;
  logic               frame_evt, evt_q;
  logic [TICK_W-1:0]  tick_q;
  logic [FRAME_W-1:0] cur_frame_q;

  // 11-bit differences keep the sprite from wrapping past the right/bottom edge
  assign dx = {1'b0, DrawX} - {1'b0, sprite_x};
  assign dy = {1'b0, DrawY} - {1'b0, sprite_y};

  always_comb begin
    hit_d = enable && (DrawX >= sprite_x) && (dx < SPAN_X) &&
            (DrawY >= sprite_y) && (dy < SPAN_Y);
    tx = TX_W'(dx >> SCALE_SHIFT);
    if (flip_h) tx = TX_W'(SPRITE_W - 1) - tx;
    ty = TY_W'(dy >> SCALE_SHIFT);
    addr_d = '0;
    if (hit_d)
      addr_d = ADDR_W'(cur_frame_q) * ADDR_W'(SPRITE_W * SPRITE_H) +
               ADDR_W'(ty) * ADDR_W'(SPRITE_W) + ADDR_W'(tx);
  end

  always_comb begin
    rgb_d = bg_q[DEPTH-1];
    if (!blank_q[DEPTH-1])
      rgb_d = '0;
    else if (hit_q[DEPTH-1] && (rom_q != IDX_W'(TRANSPARENT_IDX)))
      rgb_d = {pal_red, pal_green, pal_blue};
  end

  // Side-band delay line keeps hit/blank/bg aligned with the ROM data
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_addr_q <= '0;
      hit_q      <= '0;
      blank_q    <= '0;
      rgb_q      <= '0;
      for (int i = 0; i < DEPTH; i++) bg_q[i] <= '0;
    end else begin
      rom_addr_q <= addr_d;
      hit_q      <= {hit_q[DEPTH-2:0], hit_d};
      blank_q    <= {blank_q[DEPTH-2:0], blank};
      for (int i = DEPTH - 1; i > 0; i--) bg_q[i] <= bg_q[i-1];
      bg_q[0]    <= {bg_red, bg_green, bg_blue};
      rgb_q      <= rgb_d;
    end
  end

  // Start of the first blanking line; edge-detected so a stalled DrawX counts once
  assign frame_evt = (DrawX == 10'd0) && (DrawY == 10'd480);

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      evt_q       <= 1'b0;
      tick_q      <= '0;
      cur_frame_q <= '0;
    end else begin
      evt_q <= frame_evt;
      if (frame_evt && !evt_q && anim_en) begin
        if (tick_q == TICK_W'(FRAME_PERIOD - 1)) begin
          tick_q      <= '0;
          cur_frame_q <= (cur_frame_q == FRAME_W'(FRAMES - 1)) ? '0 : cur_frame_q + 1'b1;
        end else begin
          tick_q <= tick_q + 1'b1;
        end
      end
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pal_index = rom_q;
  assign cur_frame = cur_frame_q;
  assign {red, green, blue} = rgb_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Randomised bench for sprite_anim_renderer: a behavioural sprite/animation model
// predicts RGB (3 cycles late), rom_addr (1 cycle late) and cur_frame.
module tb_sprite_anim_renderer;

  localparam int SW = 32, SH = 32, NF = 4, IW = 3, SS = 1, FP = 8, TI = 0, RL = 1;
  localparam int AW = 12;

  logic          vga_clk;
  logic          reset;
  logic [9:0]    DrawX, DrawY, sprite_x, sprite_y;
  logic          blank, enable, anim_en, flip_h;
  logic [3:0]    bg_red, bg_green, bg_blue;
  logic [AW-1:0] rom_addr;
  logic [IW-1:0] rom_q, pal_index;
  logic [3:0]    pal_red, pal_green, pal_blue;
  logic [1:0]    cur_frame;
  logic [3:0]    red, green, blue;

  sprite_anim_renderer #(
    .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(NF), .IDX_W(IW), .SCALE_SHIFT(SS),
    .FRAME_PERIOD(FP), .TRANSPARENT_IDX(TI), .ROM_LATENCY(RL)
  ) dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .enable(enable), .anim_en(anim_en), .flip_h(flip_h),
    .sprite_x(sprite_x), .sprite_y(sprite_y),
    .bg_red(bg_red), .bg_green(bg_green), .bg_blue(bg_blue),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_index(pal_index),
    .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
    .cur_frame(cur_frame), .red(red), .green(green), .blue(blue)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  // External ROM (one cycle latency) and combinational palette
  logic [IW-1:0] romMem [1 << AW];
  logic [11:0]   palette [1 << IW];
  always @(posedge vga_clk) rom_q <= romMem[rom_addr];
  assign {pal_red, pal_green, pal_blue} = palette[pal_index];

  int          checks = 0, errors = 0;
  bit          cfgEn, cfgFlip, cfgAnim;
  int          cfgX, cfgY;
  logic [11:0] bgVal;
  int          evtCount;
  bit          prevEvt;
  logic [11:0] rgbQ [$];
  logic [31:0] expAddr;
  bit          addrValid;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int modelFrame();
    return (evtCount / FP) % NF;
  endfunction

  function automatic bit refHit(input int x, input int y);
    return cfgEn && x >= cfgX && y >= cfgY && (x - cfgX) < (SW << SS) && (y - cfgY) < (SH << SS);
  endfunction

  function automatic int refAddr(input int x, input int y);
    int tx, ty;
    if (!refHit(x, y)) return 0;
    tx = (x - cfgX) / (1 << SS);
    ty = (y - cfgY) / (1 << SS);
    if (cfgFlip) tx = SW - 1 - tx;
    return modelFrame() * SW * SH + ty * SW + tx;
  endfunction

  function automatic logic [11:0] refRgb(input int x, input int y, input bit bl);
    int idx;
    if (!bl) return 12'h000;
    if (refHit(x, y)) begin
      idx = int'(romMem[refAddr(x, y)]);
      if (idx != TI) return palette[idx];
    end
    return bgVal;
  endfunction

  // One pixel per cycle: check what has emerged, then present the next pixel
  task automatic applyStimulus(input int x, input int y);
    logic [11:0] e;
    bit bl, evt;
    @(negedge vga_clk);
    if (rgbQ.size() == 3) begin
      e = rgbQ.pop_front();
      checkOutput("rgb", {20'h0, red, green, blue}, {20'h0, e});
    end
    if (addrValid) checkOutput("rom_addr", {20'h0, rom_addr}, expAddr);
    checkOutput("cur_frame", {30'h0, cur_frame}, modelFrame());
    bl = (x < 640) && (y < 480);
    reset = 1'b0;
    DrawX = 10'(x); DrawY = 10'(y); blank = bl;
    enable = cfgEn; flip_h = cfgFlip; anim_en = cfgAnim;
    sprite_x = 10'(cfgX); sprite_y = 10'(cfgY);
    {bg_red, bg_green, bg_blue} = bgVal;
    rgbQ.push_back(refRgb(x, y, bl));
    expAddr = refAddr(x, y);
    addrValid = 1'b1;
    evt = (x == 0) && (y == 480);
    if (evt && !prevEvt && cfgAnim) evtCount++;
    prevEvt = evt;
  endtask

  task automatic doReset(input int n);
    @(negedge vga_clk);
    reset = 1'b1;
    repeat (n) begin
      @(negedge vga_clk);
      checkOutput("reset_rgb", {20'h0, red, green, blue}, 0);
      checkOutput("reset_addr", {20'h0, rom_addr}, 0);
      checkOutput("reset_frame", {30'h0, cur_frame}, 0);
    end
    rgbQ = {12'h000, 12'h000};
    addrValid = 1'b0;
    evtCount = 0;
    prevEvt = 1'b0;
  endtask

  initial begin
    reset = 1'b1; DrawX = '0; DrawY = '0; blank = 1'b0; enable = 1'b0;
    anim_en = 1'b0; flip_h = 1'b0; sprite_x = '0; sprite_y = '0;
    {bg_red, bg_green, bg_blue} = '0;
    for (int i = 0; i < (1 << AW); i++) romMem[i] = IW'($urandom_range(0, 7));
    romMem[0] = 3'd2;
    romMem[1] = 3'(TI);
    for (int i = 0; i < (1 << IW); i++) palette[i] = 12'($urandom);
    palette[0] = 12'hFFF;
    palette[2] = 12'hA1C;
    cfgEn = 0; cfgFlip = 0; cfgAnim = 0; cfgX = 100; cfgY = 50; bgVal = 12'h357;
    evtCount = 0; prevEvt = 0; addrValid = 0;

    doReset(3);

    // Sprite disabled: background in the visible area, black in blanking
    for (int x = 630; x < 650; x++) applyStimulus(x, 10);
    for (int x = 0; x < 4; x++) begin applyStimulus(x, 479); applyStimulus(x, 480); end
    repeat (150) applyStimulus($urandom_range(0, 799), $urandom_range(0, 524));

    // Sprite at (100,50), unflipped then flipped; texel (1,0) is transparent
    cfgEn = 1;
    for (int y = 49; y < 53; y++)
      for (int x = 98; x < 167; x++) applyStimulus(x, y);
    cfgFlip = 1;
    for (int y = 50; y < 52; y++)
      for (int x = 98; x < 167; x++) applyStimulus(x, y);
    cfgFlip = 0;

    // Animation: 42 frame events, the first one stalled for three cycles
    cfgAnim = 1;
    for (int e = 0; e < 42; e++) begin
      applyStimulus(0, 480);
      if (e == 0) begin applyStimulus(0, 480); applyStimulus(0, 480); end
      applyStimulus(1, 480);
      bgVal = 12'($urandom);
      applyStimulus(100 + $urandom_range(0, 63), 50 + $urandom_range(0, 63));
      if (e == 6)  checkOutput("frame_after_7evt", {30'h0, cur_frame}, 0);
      if (e == 7)  checkOutput("frame_after_8evt", {30'h0, cur_frame}, 1);
      if (e == 31) checkOutput("frame_after_32evt", {30'h0, cur_frame}, 0);
      if (e == 41) checkOutput("frame_after_42evt", {30'h0, cur_frame}, 1);
    end
    cfgAnim = 0;
    for (int e = 0; e < 10; e++) begin
      applyStimulus(0, 480);
      applyStimulus(1, 480);
    end
    checkOutput("frame_hold_anim_off", {30'h0, cur_frame}, 1);
    for (int i = 0; i < 20; i++) applyStimulus(100 + 3 * i, 60 + i);

    // Right-edge sprite: no wrap back to the left of the screen
    cfgX = 620; cfgY = 100; bgVal = 12'h357;
    for (int y = 100; y < 102; y++) begin
      for (int x = 600; x < 700; x++) applyStimulus(x, y);
      for (int x = 0; x < 50; x++) applyStimulus(x, y);
    end
    cfgFlip = 1;
    for (int x = 610; x < 645; x++) applyStimulus(x, 130);
    cfgFlip = 0;

    // Reset in the middle of a line, then resume the scan
    cfgX = 280; cfgY = 195;
    for (int x = 250; x <= 300; x++) applyStimulus(x, 200);
    doReset(2);
    for (int x = 301; x < 345; x++) applyStimulus(x, 200);

    // Randomised configurations, pixels and frame events
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        cfgEn = ($urandom_range(0, 3) != 0);
        cfgFlip = $urandom_range(0, 1) != 0;
        cfgAnim = $urandom_range(0, 1) != 0;
        cfgX = $urandom_range(0, 700);
        cfgY = $urandom_range(0, 500);
      end
      bgVal = 12'($urandom);
      case ($urandom_range(0, 3))
        0:       applyStimulus(0, 480);
        1:       applyStimulus($urandom_range(0, 799), $urandom_range(0, 524));
        default: applyStimulus(cfgX + $urandom_range(0, 70), cfgY + $urandom_range(0, 70));
      endcase
    end
    repeat (3) applyStimulus(5, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_anim_renderer.md
# sprite_anim_renderer

Parametrised, position-aware sprite renderer for the VGA pixel path. It maps the current DrawX/DrawY into a multi-frame sprite sheet held in an external synchronous ROM, and applies power-of-two scaling, horizontal flip and a transparent colour key. It composites the sprite over a background colour and cycles animation frames at a programmable rate. It sits between the VGA controller and the 4-bit DAC outputs, one instance per on-screen sprite.

## Interface
- SPRITE_W, 32: sprite width in texels, power of two
- SPRITE_H, 32: sprite height in texels, power of two
- FRAMES, 4: animation frames stored back-to-back in the ROM, power of two
- IDX_W, 3: palette index width (ROM word width)
- SCALE_SHIFT, 1: on-screen scale = 2^SCALE_SHIFT screen pixels per texel, each axis
- FRAME_PERIOD, 8: video frames per animation step, ≥1
- TRANSPARENT_IDX, 0: palette index treated as see-through
- ROM_LATENCY, 1: ROM read latency in vga_clk cycles, 1 or 2
- localparam ADDR_W = clog2(FRAMES*SPRITE_W*SPRITE_H) (12 at defaults)
- Clock/reset: single clock `vga_clk`; reset `reset` is synchronous, active-high
- vga_clk  in  1  pixel clock; DrawX advances once per cycle
- reset  in  1  synchronous, active-high
- DrawX, DrawY  in  10 each  current pixel coordinates
- blank  in  1  1 = visible region, 0 = blanking
- enable  in  1  sprite drawn when 1
- anim_en  in  1  animation advances when 1
- flip_h  in  1  mirror sprite horizontally
- sprite_x, sprite_y  in  10 each  screen position of the sprite's top-left corner
- bg_red, bg_green, bg_blue  in  4 each  background colour, aligned with DrawX/DrawY
- rom_addr  out  ADDR_W  registered ROM address
- rom_q  in  IDX_W  ROM data, valid ROM_LATENCY cycles after rom_addr
- pal_index  out  IDX_W  combinationally equal to rom_q; feeds the external palette
- pal_red, pal_green, pal_blue  in  4 each  combinational palette output for pal_index
- cur_frame  out  clog2(FRAMES)  current animation frame
- red, green, blue  out  4 each  registered pixel colour

## Operation
- Stage A (combinational on DrawX/DrawY):
  - Compute in 11 bits, with no wrap at the right/bottom screen edge: dx = DrawX − sprite_x, dy = DrawY − sprite_y.
  - hit = enable & DrawX ≥ sprite_x & dx < SPRITE_W<<SCALE_SHIFT & DrawY ≥ sprite_y & dy < SPRITE_H<<SCALE_SHIFT.
  - tx = dx>>SCALE_SHIFT, ty = dy>>SCALE_SHIFT. If flip_h, tx := SPRITE_W−1−tx.
  - addr = cur_frame*SPRITE_W*SPRITE_H + ty*SPRITE_W + tx. When hit = 0, addr = 0.
- Stage B: register rom_addr. Along with it, register hit, blank and the bg colour into a delay line of depth 1+ROM_LATENCY.
- Output stage, registered:
  - delayed blank = 0 → RGB = 0.
  - Otherwise, delayed hit = 1 and rom_q ≠ TRANSPARENT_IDX → RGB = pal_*.
  - Otherwise → RGB = delayed bg.
- Animation:
  - frame_evt = (DrawX == 0 && DrawY == 480), i.e. start of the first blanking line, so a frame swap never tears.
  - On frame_evt with anim_en = 1: tick_cnt increments. When tick_cnt == FRAME_PERIOD−1, tick_cnt := 0 and cur_frame := cur_frame+1 mod FRAMES, wrapping FRAMES−1 → 0.
  - anim_en = 0 holds both tick_cnt and cur_frame.
  - frame_evt lasting more than one cycle (DrawX stalled) counts once: a rising-edge detect on frame_evt is required.

## Timing
- Pixel-to-RGB latency is fixed at 2+ROM_LATENCY cycles (3 at defaults). The VGA controller's sync signals must be delayed by the same amount downstream.
- Reset (synchronous): red/green/blue = 0, rom_addr = 0, cur_frame = 0, tick_cnt = 0, all delay-line bits cleared (blank_d = 0).
- After reset is released, RGB stays 0 until real pixels emerge from the pipeline, 2+ROM_LATENCY cycles later.
- Reset asserted mid-line: RGB = 0 from the next edge; no stale pixels emerge after release.
- Changes to sprite_x/sprite_y/flip_h/enable take effect for the pixel presented in the same cycle. The intended use is to change them only during blanking.
- frame_evt and reset in the same cycle: reset wins.
- One throughput pixel per cycle, with no stalls or backpressure.

## Test plan
- Reset, then scan a full 800×525 frame with enable = 0, bg = 0x3/0x5/0x7 → every visible pixel is (3,5,7) exactly 3 cycles after its DrawX; every blank pixel is (0,0,0).
- sprite_x = 100, sprite_y = 50, SCALE_SHIFT = 1, ROM texel(0,0) = idx 2 → pixels (100..101, 50..51) show pal[2], and rom_addr = 0 for those pixels. Pixel (164,50) is outside the sprite → bg.
- flip_h = 1, same position → DrawX = 100 yields rom_addr = 31 (tx = 31); DrawX = 163 yields rom_addr = 0.
- Texel idx = TRANSPARENT_IDX inside the sprite → output equals bg, not pal[0].
- anim_en = 1, FRAME_PERIOD = 8 → cur_frame steps 0→1 after the 8th frame_evt and wraps 3→0 after the 32nd. With anim_en = 0 for 10 frames, cur_frame does not change.
- sprite_x = 620 → pixels 620..639 are drawn and nothing wraps to DrawX 0..43. Asserting reset at DrawX = 300 gives RGB = 0 on the next edge and for 3 cycles after release.
